// File: rtl/micro_tlb_pkg.sv
// Shared types and default widths for the micro-TLB.
package micro_tlb_pkg;

  localparam int UTLB_ENTRIES = 4;
  localparam int UTLB_VPN_W   = 20;
  localparam int UTLB_PFN_W   = 20;
  localparam int UTLB_ASID_W  = 8;

  typedef enum logic [1:0] {
    UTLB_IDLE   = 2'd0,
    UTLB_REFILL = 2'd1,
    UTLB_RESP   = 2'd2
  } utlb_state_t;

endpackage

// File: rtl/micro_tlb_if.sv
// Core-side lookup port plus main-TLB refill port of one micro-TLB instance.
interface micro_tlb_if #(
  parameter int VPN_W  = micro_tlb_pkg::UTLB_VPN_W,
  parameter int PFN_W  = micro_tlb_pkg::UTLB_PFN_W,
  parameter int ASID_W = micro_tlb_pkg::UTLB_ASID_W
);
  // Lookup: a request is taken on a cycle where req_valid && req_ready; the
  // requester keeps vpn/asid stable that cycle. resp_valid is a single-cycle
  // strobe with no backpressure. Refill: mtlb_req stays high with a stable
  // mtlb_vpn until the cycle mtlb_ack is seen with the result fields.
  logic              req_valid;
  logic              req_ready;
  logic [VPN_W-1:0]  req_vpn;
  logic [ASID_W-1:0] req_asid;

  logic              resp_valid;
  logic              resp_hit;
  logic              resp_v;
  logic              resp_d;
  logic              resp_c;
  logic              resp_err;
  logic [PFN_W-1:0]  resp_pfn;

  logic              mtlb_req;
  logic [VPN_W-1:0]  mtlb_vpn;
  logic              mtlb_ack;
  logic              mtlb_hit;
  logic              mtlb_v;
  logic              mtlb_d;
  logic              mtlb_c;
  logic              mtlb_g;
  logic              mtlb_err;
  logic [PFN_W-1:0]  mtlb_pfn;

  logic              flush;

  modport slave (
    input  req_valid, req_vpn, req_asid,
    output req_ready,
    output resp_valid, resp_hit, resp_v, resp_d, resp_c, resp_err, resp_pfn,
    output mtlb_req, mtlb_vpn,
    input  mtlb_ack, mtlb_hit, mtlb_v, mtlb_d, mtlb_c, mtlb_g, mtlb_err, mtlb_pfn,
    input  flush
  );

  modport master (
    output req_valid, req_vpn, req_asid,
    input  req_ready,
    input  resp_valid, resp_hit, resp_v, resp_d, resp_c, resp_err, resp_pfn,
    input  mtlb_req, mtlb_vpn,
    output mtlb_ack, mtlb_hit, mtlb_v, mtlb_d, mtlb_c, mtlb_g, mtlb_err, mtlb_pfn,
    output flush
  );

endinterface

// File: rtl/micro_tlb_victim_sel.sv
// Picks the slot to overwrite on install: lowest-index free slot, else the RR pointer.
module micro_tlb_victim_sel #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_i,
  output logic [IDX_W-1:0]   victim_o,
  output logic               evict_o
);

  always_comb begin
    victim_o = rr_i;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_o = IDX_W'(i);
    end
  end

  // Only a full table forces a valid slot out.
  assign evict_o = &valid_i;

endmodule

// File: rtl/micro_tlb.sv
// Fully-associative micro-TLB with ASID/global tagging, main-TLB refill and flush.
module micro_tlb
  import micro_tlb_pkg::*;
#(
  parameter int ENTRIES = UTLB_ENTRIES,
  parameter int VPN_W   = UTLB_VPN_W,
  parameter int PFN_W   = UTLB_PFN_W,
  parameter int ASID_W  = UTLB_ASID_W
) (
  input  logic        clk,
  input  logic        reset,
  micro_tlb_if.slave  bus,
  output utlb_state_t state_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn;
    logic              d;
    logic              c;
  } slot_t;

  utlb_state_t       state_q, state_d;
  logic [ENTRIES-1:0] valid_q;
  slot_t             slot_q [ENTRIES];
  logic [IDX_W-1:0]  rr_q;
  logic              flush_pending_q;
  logic [VPN_W-1:0]  lat_vpn_q;
  logic [ASID_W-1:0] lat_asid_q;

  logic              resp_valid_q, resp_hit_q, resp_v_q, resp_d_q, resp_c_q, resp_err_q;
  logic [PFN_W-1:0]  resp_pfn_q;

  logic [ENTRIES-1:0] match;
  logic [IDX_W-1:0]  hit_idx;
  logic              lookup_hit;
  logic              install;
  logic [IDX_W-1:0]  victim;
  logic              evict;

  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid_q[i] && (slot_q[i].vpn == bus.req_vpn) &&
                 (slot_q[i].g || (slot_q[i].asid == bus.req_asid));
    end
  end

  always_comb begin
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
    end
  end

  // A flush in the same cycle as a request turns the lookup into a miss.
  assign lookup_hit = bus.req_valid && (|match) && !bus.flush;

  assign install = (state_q == UTLB_REFILL) && bus.mtlb_ack && bus.mtlb_hit &&
                   bus.mtlb_v && !bus.mtlb_err && !flush_pending_q && !bus.flush;

  micro_tlb_victim_sel #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_victim (
    .valid_i  (valid_q),
    .rr_i     (rr_q),
    .victim_o (victim),
    .evict_o  (evict)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= UTLB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UTLB_IDLE:   if (bus.req_valid && !lookup_hit) state_d = UTLB_REFILL;
      UTLB_REFILL: if (bus.mtlb_ack) state_d = UTLB_RESP;
      UTLB_RESP:   state_d = UTLB_IDLE;
      default:     state_d = UTLB_IDLE;
    endcase
  end

  assign state_o       = state_q;
  assign bus.req_ready = (state_q == UTLB_IDLE);
  assign bus.mtlb_req  = (state_q == UTLB_REFILL);
  assign bus.mtlb_vpn  = lat_vpn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (install) begin
      valid_q[victim] <= 1'b1;
      if (evict) rr_q <= rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      slot_q[victim] <= '{vpn: lat_vpn_q, asid: lat_asid_q, g: bus.mtlb_g,
                          pfn: bus.mtlb_pfn, d: bus.mtlb_d, c: bus.mtlb_c};
    end
  end

  // A flush seen while waiting on the main TLB must stop the stale result being cached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       flush_pending_q <= 1'b0;
    else if (state_q == UTLB_RESP)                   flush_pending_q <= 1'b0;
    else if (state_q == UTLB_REFILL && bus.flush)    flush_pending_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_vpn_q  <= '0;
      lat_asid_q <= '0;
    end else if (state_q == UTLB_IDLE && bus.req_valid) begin
      lat_vpn_q  <= bus.req_vpn;
      lat_asid_q <= bus.req_asid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_v_q     <= 1'b0;
      resp_d_q     <= 1'b0;
      resp_c_q     <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_pfn_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (state_q == UTLB_IDLE && lookup_hit) begin
        resp_valid_q <= 1'b1;
        resp_hit_q   <= 1'b1;
        resp_v_q     <= 1'b1;
        resp_d_q     <= slot_q[hit_idx].d;
        resp_c_q     <= slot_q[hit_idx].c;
        resp_err_q   <= 1'b0;
        resp_pfn_q   <= slot_q[hit_idx].pfn;
      end else if (state_q == UTLB_REFILL && bus.mtlb_ack) begin
        resp_valid_q <= 1'b1;
        resp_hit_q   <= bus.mtlb_hit;
        resp_v_q     <= bus.mtlb_v;
        resp_d_q     <= bus.mtlb_d;
        resp_c_q     <= bus.mtlb_c;
        resp_err_q   <= bus.mtlb_err;
        resp_pfn_q   <= bus.mtlb_pfn;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_v     = resp_v_q;
  assign bus.resp_d     = resp_d_q;
  assign bus.resp_c     = resp_c_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_pfn   = resp_pfn_q;

  a_single_match: assert property (@(posedge clk) disable iff (reset) $onehot0(match));

endmodule

// File: tb/tb_micro_tlb.sv
// Directed plus randomized bench for micro_tlb against a slot-table reference model.
module tb_micro_tlb;
  import micro_tlb_pkg::*;

  localparam int ENTRIES = 4;
  localparam int VPN_W   = 20;
  localparam int PFN_W   = 20;
  localparam int ASID_W  = 8;
  localparam int POOL    = 8;

  typedef struct packed {
    logic hit, v, d, c, g, err;
    logic [PFN_W-1:0] pfn;
  } mres_t;

  logic        clk = 1'b0;
  logic        reset;
  utlb_state_t state;

  micro_tlb_if #(.VPN_W(VPN_W), .PFN_W(PFN_W), .ASID_W(ASID_W)) bus ();

  micro_tlb #(.ENTRIES(ENTRIES), .VPN_W(VPN_W), .PFN_W(PFN_W), .ASID_W(ASID_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  bit last_refilled;

  // Reference model: the cached translations as a plain table.
  bit               m_valid [ENTRIES];
  logic [VPN_W-1:0] m_vpn   [ENTRIES];
  logic [ASID_W-1:0] m_asid [ENTRIES];
  bit               m_g     [ENTRIES];
  logic [PFN_W-1:0] m_pfn   [ENTRIES];
  bit               m_d     [ENTRIES];
  bit               m_c     [ENTRIES];
  int               m_rr;

  logic [VPN_W-1:0] pg_vpn [POOL];
  mres_t            pg_res [POOL];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid);
    int idx = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_vpn[i] == vpn && (m_g[i] || m_asid[i] == asid)) idx = i;
    return idx;
  endfunction

  function automatic void m_flush();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void m_install(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                                    input mres_t r);
    int slot = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (!m_valid[i] && slot < 0) slot = i;
    if (slot < 0) begin
      slot = m_rr;
      m_rr = (m_rr + 1) % ENTRIES;
    end
    m_valid[slot] = 1'b1;
    m_vpn[slot]   = vpn;
    m_asid[slot]  = asid;
    m_g[slot]     = r.g;
    m_pfn[slot]   = r.pfn;
    m_d[slot]     = r.d;
    m_c[slot]     = r.c;
  endfunction

  task automatic scramble_mtlb();
    bus.mtlb_hit = 1'($urandom); bus.mtlb_v = 1'($urandom); bus.mtlb_d = 1'($urandom);
    bus.mtlb_c = 1'($urandom); bus.mtlb_g = 1'($urandom); bus.mtlb_err = 1'($urandom);
    bus.mtlb_pfn = PFN_W'($urandom);
  endtask

  task automatic idle_flush();
    bus.flush = 1'b1;
    m_flush();
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  // One lookup; ack arrives dly cycles after mtlb_req rises, flush_cyc (0 = none) is a REFILL cycle.
  task automatic lookup(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid, input mres_t r,
                        input int dly, input int flush_cyc, input bit flush_same);
    int idx;
    bit flushed;
    idx     = flush_same ? -1 : m_find(vpn, asid);
    flushed = flush_same;
    if (flush_same) m_flush();
    check("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1; bus.req_vpn = vpn; bus.req_asid = asid; bus.flush = flush_same;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    bus.req_vpn = VPN_W'($urandom); bus.req_asid = ASID_W'($urandom);
    last_refilled = bus.mtlb_req;
    if (idx >= 0) begin
      check("hit_resp_valid", 32'(bus.resp_valid), 1);
      check("hit_resp_hit",   32'(bus.resp_hit), 1);
      check("hit_resp_v",     32'(bus.resp_v), 1);
      check("hit_resp_err",   32'(bus.resp_err), 0);
      check("hit_resp_d",     32'(bus.resp_d), 32'(m_d[idx]));
      check("hit_resp_c",     32'(bus.resp_c), 32'(m_c[idx]));
      check("hit_resp_pfn",   32'(bus.resp_pfn), 32'(m_pfn[idx]));
      check("hit_no_mtlb_req", 32'(bus.mtlb_req), 0);
      check("hit_req_ready",  32'(bus.req_ready), 1);
    end else begin
      for (int c = 1; c <= dly + 1; c++) begin
        check("refill_mtlb_req",  32'(bus.mtlb_req), 1);
        check("refill_mtlb_vpn",  32'(bus.mtlb_vpn), 32'(vpn));
        check("refill_req_ready", 32'(bus.req_ready), 0);
        check("refill_no_resp",   32'(bus.resp_valid), 0);
        if (c == dly + 1) begin
          bus.mtlb_ack = 1'b1; bus.mtlb_hit = r.hit; bus.mtlb_v = r.v; bus.mtlb_d = r.d;
          bus.mtlb_c = r.c; bus.mtlb_g = r.g; bus.mtlb_err = r.err; bus.mtlb_pfn = r.pfn;
        end
        if (c == flush_cyc) begin
          bus.flush = 1'b1;
          flushed   = 1'b1;
          m_flush();
        end
        @(negedge clk);
        bus.mtlb_ack = 1'b0; bus.flush = 1'b0;
        scramble_mtlb();
      end
      check("miss_resp_valid", 32'(bus.resp_valid), 1);
      check("miss_resp_hit",   32'(bus.resp_hit), 32'(r.hit));
      check("miss_resp_v",     32'(bus.resp_v), 32'(r.v));
      check("miss_resp_d",     32'(bus.resp_d), 32'(r.d));
      check("miss_resp_c",     32'(bus.resp_c), 32'(r.c));
      check("miss_resp_err",   32'(bus.resp_err), 32'(r.err));
      check("miss_resp_pfn",   32'(bus.resp_pfn), 32'(r.pfn));
      check("resp_no_mtlb_req", 32'(bus.mtlb_req), 0);
      if (r.hit && r.v && !r.err && !flushed) m_install(vpn, asid, r);
      @(negedge clk);
      check("resp_strobe_1cyc", 32'(bus.resp_valid), 0);
      check("resp_pfn_hold",    32'(bus.resp_pfn), 32'(r.pfn));
      check("back_to_idle",     32'(bus.req_ready), 1);
    end
  endtask

  function automatic mres_t mk(input bit hit, input bit v, input bit err, input bit g,
                               input logic [PFN_W-1:0] pfn);
    mres_t r;
    r.hit = hit; r.v = v; r.err = err; r.g = g; r.pfn = pfn;
    r.d = 1'($urandom); r.c = 1'($urandom);
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_vpn = '0; bus.req_asid = '0; bus.flush = 1'b0;
    bus.mtlb_ack = 1'b0;
    scramble_mtlb();
    m_flush();
    m_rr = 0;
    for (int k = 0; k < POOL; k++) begin
      pg_vpn[k] = VPN_W'(32'h20000 + k * 32'h111);
      pg_res[k] = mk($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 9) == 0, 1'($urandom), PFN_W'($urandom));
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_req_ready",  32'(bus.req_ready), 1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_hit",   32'(bus.resp_hit), 0);
    check("rst_resp_v",     32'(bus.resp_v), 0);
    check("rst_resp_err",   32'(bus.resp_err), 0);
    check("rst_resp_pfn",   32'(bus.resp_pfn), 0);
    check("rst_mtlb_req",   32'(bus.mtlb_req), 0);
    check("rst_state",      32'(state), 32'(UTLB_IDLE));

    // 1: first lookup refills with resp at cycle 5, repeat hits in 1 cycle
    lookup(20'h00400, 8'h01, mk(1, 1, 0, 0, 20'h1F000), 3, 0, 0);
    check("t1_refilled", 32'(last_refilled), 1);
    check("t1_pfn", 32'(bus.resp_pfn), 32'h1F000);
    lookup(20'h00400, 8'h01, mk(1, 1, 0, 0, 20'h0), 1, 0, 0);
    check("t1_repeat_hit", 32'(last_refilled), 0);
    check("t1_repeat_pfn", 32'(bus.resp_pfn), 32'h1F000);

    // 2: ENTRIES+1 pages; the last evicts slot 0
    idle_flush();
    for (int i = 0; i <= ENTRIES; i++)
      lookup(VPN_W'(32'h00100 + i), 8'h01, mk(1, 1, 0, 0, PFN_W'(32'h3000 + i)), 1, 0, 0);
    for (int i = 1; i <= ENTRIES; i++) begin
      lookup(VPN_W'(32'h00100 + i), 8'h01, mk(1, 1, 0, 0, 20'h0), 1, 0, 0);
      check("t2_survivor_hit", 32'(last_refilled), 0);
    end
    lookup(20'h00100, 8'h01, mk(1, 1, 0, 0, 20'h03000), 2, 0, 0);
    check("t2_evicted_refill", 32'(last_refilled), 1);

    // 3: ASID tagging and global pages
    idle_flush();
    lookup(20'h12345, 8'h05, mk(1, 1, 0, 0, 20'hAAAAA), 1, 0, 0);
    lookup(20'h12345, 8'h06, mk(1, 1, 0, 1, 20'hBBBBB), 2, 0, 0);
    check("t3_asid_miss", 32'(last_refilled), 1);
    lookup(20'h12345, 8'h06, mk(1, 1, 0, 1, 20'h0), 1, 0, 0);
    check("t3_global_hit", 32'(last_refilled), 0);
    check("t3_global_pfn", 32'(bus.resp_pfn), 32'hBBBBB);
    idle_flush();

    // 4: invalid and error translations are never cached
    lookup(20'h0ABCD, 8'h01, mk(1, 0, 0, 0, 20'h11111), 1, 0, 0);
    check("t4_resp_v0", 32'(bus.resp_v), 0);
    lookup(20'h0ABCD, 8'h01, mk(1, 0, 0, 0, 20'h11111), 1, 0, 0);
    check("t4_v0_refills", 32'(last_refilled), 1);
    lookup(20'h0ABCE, 8'h01, mk(0, 0, 1, 0, 20'h22222), 2, 0, 0);
    check("t4_resp_err", 32'(bus.resp_err), 1);
    lookup(20'h0ABCE, 8'h01, mk(0, 0, 1, 0, 20'h22222), 1, 0, 0);
    check("t4_err_refills", 32'(last_refilled), 1);

    // 5: flush during refill, and flush with a request
    lookup(20'h05000, 8'h01, mk(1, 1, 0, 0, 20'h05555), 1, 0, 0);
    lookup(20'h06000, 8'h01, mk(1, 1, 0, 0, 20'h06666), 3, 2, 0);
    check("t5_flush_resp_pfn", 32'(bus.resp_pfn), 32'h06666);
    lookup(20'h06000, 8'h01, mk(1, 1, 0, 0, 20'h06666), 1, 0, 0);
    check("t5_not_installed", 32'(last_refilled), 1);
    lookup(20'h06000, 8'h01, mk(1, 1, 0, 0, 20'h06666), 1, 0, 0);
    check("t5_now_hits", 32'(last_refilled), 0);
    lookup(20'h06000, 8'h01, mk(1, 1, 0, 0, 20'h06666), 1, 0, 1);
    check("t5_flush_same_miss", 32'(last_refilled), 1);
    lookup(20'h07000, 8'h01, mk(1, 1, 0, 0, 20'h07777), 2, 3, 0);

    // 6: reset while mtlb_req is high
    bus.req_valid = 1'b1; bus.req_vpn = 20'h09000; bus.req_asid = 8'h01;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("t6_in_refill", 32'(bus.mtlb_req), 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_mtlb_req", 32'(bus.mtlb_req), 0);
    check("t6_async_resp_valid", 32'(bus.resp_valid), 0);
    check("t6_async_state", 32'(state), 32'(UTLB_IDLE));
    @(negedge clk);
    reset = 1'b0;
    m_flush();
    m_rr = 0;
    @(negedge clk);
    check("t6_ready_after", 32'(bus.req_ready), 1);
    lookup(20'h06000, 8'h01, mk(1, 1, 0, 0, 20'h06666), 1, 0, 0);
    check("t6_cleared", 32'(last_refilled), 1);

    // Randomized traffic over a small page pool
    idle_flush();
    for (int n = 0; n < 60; n++) begin
      int k, dly, fc;
      k   = $urandom_range(0, POOL - 1);
      dly = $urandom_range(1, 4);
      fc  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, dly + 1) : 0;
      if ($urandom_range(0, 11) == 0) idle_flush();
      lookup(pg_vpn[k], ASID_W'($urandom_range(1, 2)), pg_res[k], dly, fc,
             $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
